regfile_burst_reader: RTL and testbench

REGFILE_BURST_READER -- requirements
Module: regfile_burst_reader

---
 rtl/regfile_burst_reader_if.sv | 27 ++
 rtl/regfile_burst_reader.sv | 133 +++++++++++++
 tb/tb_regfile_burst_reader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_burst_reader_if.sv
// Burst-request, register-file read and output-stream signals of regfile_burst_reader.
// The slave modport is the reader's view; master is the environment's.
interface regfile_burst_reader_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [2:0]        start_addr;
  logic [3:0]        count;
  logic              busy;
  logic              done;
  logic              rf_enable_read;
  logic [2:0]        rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  start, start_addr, count, rf_data, out_ready,
    output busy, done, rf_enable_read, rf_addr, out_data, out_valid
  );

  modport master (
    output start, start_addr, count, rf_data, out_ready,
    input  busy, done, rf_enable_read, rf_addr, out_data, out_valid
  );
endinterface

// File: rtl/regfile_burst_reader.sv
// Reads a burst of up to 8 consecutive (mod 8) words from an 8-entry register file
// and streams them out through a two-entry buffer with valid/ready flow control.
module regfile_burst_reader #(
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 2
) (
  input logic                    clock,
  input logic                    reset,
  regfile_burst_reader_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        addr_q, addr_d;
  logic [3:0]        remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic              done_q, done_d;
  logic              pop;
  logic              issue;
  logic [1:0]        used;

  // Next-state, issue decision and buffer bookkeeping.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    buf_d       = buf_q;
    pop         = (occ_q != 2'd0) && bus.out_ready;
    // Occupancy is counted net of the word leaving this cycle so a steady stream keeps one read per cycle.
    used        = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    issue       = (state_q == READ) && (remaining_q != 4'd0) && (used < 2'(BUF_DEPTH));
    inflight_d  = issue;
    occ_d       = used;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.count == 4'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = bus.start_addr;
            remaining_d = (bus.count > 4'd8) ? 4'd8 : bus.count;
            state_d     = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (issue) begin
          addr_d      = addr_q + 3'd1;
          remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1) begin
            state_d = DRAIN;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        if ((occ_q == 2'd0) && !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Read data returns one cycle after its issue and lands at the write pointer.
    if (inflight_q) begin
      buf_d[wr_ptr_q] = bus.rf_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State and datapath registers; reset abandons any burst in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= 3'd0;
      remaining_q <= 4'd0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      buf_q       <= '{default: '0};
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      buf_q       <= buf_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy           = (state_q != IDLE);
  assign bus.done           = done_q;
  assign bus.rf_enable_read = issue;
  assign bus.rf_addr        = addr_q;
  assign bus.out_data       = buf_q[rd_ptr_q];
  assign bus.out_valid      = (occ_q != 2'd0);
endmodule

// File: tb/tb_regfile_burst_reader.sv
// Directed self-checking bench for regfile_burst_reader with an 8x16 register-file model.
module tb_regfile_burst_reader;
  localparam int DATA_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;

  logic [15:0] out_q[$];
  int          out_cyc[$];
  logic [2:0]  iss_q[$];
  int          iss_cyc[$];
  int          done_cnt = 0;
  int          busy_cnt = 0;

  regfile_burst_reader_if #(.DATA_W(DATA_W)) bus ();

  regfile_burst_reader #(.DATA_W(DATA_W), .BUF_DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Register file: regs[i] = 16'h1000 + i, data valid the cycle after the strobe.
  always @(posedge clock) begin
    if (bus.rf_enable_read === 1'b1) bus.rf_data <= 16'h1000 + {13'd0, bus.rf_addr};
    else                             bus.rf_data <= 16'hDEAD;
  end

  // Mid-cycle monitor of transfers, issued reads, done pulses and busy cycles.
  always @(negedge clock) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      out_q.push_back(bus.out_data);
      out_cyc.push_back(cyc);
    end
    if (bus.rf_enable_read === 1'b1) begin
      iss_q.push_back(bus.rf_addr);
      iss_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) done_cnt = done_cnt + 1;
    if (bus.busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    out_q.delete();
    out_cyc.delete();
    iss_q.delete();
    iss_cyc.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1;
    bus.start = 1'b0; bus.start_addr = 3'd5; bus.count = 4'd4; bus.out_ready = 1'b1;
    repeat (3) tick();
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.rf_enable_read !== 1'b0) $display("FAIL reset_en got %b want 0", bus.rf_enable_read); else pass_cnt++;
    total_cnt++; if (bus.rf_addr !== 3'd0) $display("FAIL reset_addr got %0d want 0", bus.rf_addr); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 16'h0000) $display("FAIL reset_data got %h want 0000", bus.out_data); else pass_cnt++;
    // Release reset and request immediately: accepted on the first edge.
    @(negedge clock);
    reset = 1'b0;
    clear_mon();
    bus.start = 1'b1; bus.start_addr = 3'd3; bus.count = 4'd1;
    tick();
    bus.start = 1'b0;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL first_start_busy got %b want 1", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.rf_enable_read !== 1'b1 || bus.rf_addr !== 3'd3)
      $display("FAIL first_start_issue got en=%b addr=%0d want en=1 addr=3", bus.rf_enable_read, bus.rf_addr); else pass_cnt++;
    wait_done(20, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL first_start_done got timeout want done"); else pass_cnt++;
    total_cnt++; if (out_q.size() != 1 || out_q[0] !== 16'h1003)
      $display("FAIL first_start_word got n=%0d want one word 1003", out_q.size()); else pass_cnt++;
  endtask

  task automatic test_basic();
    bit ok;
    logic [15:0] exp_w [3] = '{16'h1001, 16'h1002, 16'h1003};
    clear_mon();
    bus.out_ready = 1'b1; bus.start_addr = 3'd1; bus.count = 4'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(40, ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL basic_done got timeout want done"); else pass_cnt++;
    total_cnt++; if (out_q.size() != 3) $display("FAIL basic_count got %0d want 3", out_q.size()); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (out_q[i] !== exp_w[i]) $display("FAIL basic_word%0d got %h want %h", i, out_q[i], exp_w[i]); else pass_cnt++;
    end
    total_cnt++; if (out_cyc[1] - out_cyc[0] != 1 || out_cyc[2] - out_cyc[1] != 1)
      $display("FAIL basic_back2back got gaps %0d,%0d want 1,1", out_cyc[1] - out_cyc[0], out_cyc[2] - out_cyc[1]); else pass_cnt++;
    total_cnt++; if (out_cyc[0] - iss_cyc[0] != 2) $display("FAIL basic_latency got %0d want 2", out_cyc[0] - iss_cyc[0]); else pass_cnt++;
    total_cnt++; if (done_cnt != 1) $display("FAIL basic_done_pulses got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_end got %b want 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [2:0]  exp_a [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [15:0] exp_w [4] = '{16'h1006, 16'h1007, 16'h1000, 16'h1001};
    clear_mon();
    bus.start_addr = 3'd6; bus.count = 4'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(40, ok);
    total_cnt++; if (ok !== 1'b1 || out_q.size() != 4 || iss_q.size() != 4)
      $display("FAIL wrap_sizes got ok=%b words=%0d reads=%0d want 1,4,4", ok, out_q.size(), iss_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (iss_q[i] !== exp_a[i]) $display("FAIL wrap_addr%0d got %0d want %0d", i, iss_q[i], exp_a[i]); else pass_cnt++;
      total_cnt++; if (out_q[i] !== exp_w[i]) $display("FAIL wrap_word%0d got %h want %h", i, out_q[i], exp_w[i]); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_mon();
    bus.out_ready = 1'b0; bus.start_addr = 3'd0; bus.count = 4'd8; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1000)
        $display("FAIL stall_hold%0d got valid=%b data=%h want 1,1000", i, bus.out_valid, bus.out_data); else pass_cnt++;
      tick();
    end
    total_cnt++; if (iss_q.size() > 2) $display("FAIL stall_reads got %0d want at most 2", iss_q.size()); else pass_cnt++;
    bus.out_ready = 1'b1;
    wait_done(60, ok);
    total_cnt++; if (ok !== 1'b1 || out_q.size() != 8)
      $display("FAIL stall_total got ok=%b words=%0d want 1,8", ok, out_q.size()); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++; if (out_q[i] !== 16'h1000 + i) $display("FAIL stall_word%0d got %h want %h", i, out_q[i], 16'h1000 + i); else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL stall_done_pulses got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_count_zero();
    clear_mon();
    bus.start_addr = 3'd4; bus.count = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    @(negedge clock);
    total_cnt++; if (bus.done !== 1'b1) $display("FAIL zero_done got %b want 1", bus.done); else pass_cnt++;
    repeat (6) tick();
    total_cnt++; if (done_cnt != 1) $display("FAIL zero_done_pulses got %0d want 1", done_cnt); else pass_cnt++;
    total_cnt++; if (iss_q.size() != 0) $display("FAIL zero_reads got %0d want 0", iss_q.size()); else pass_cnt++;
    total_cnt++; if (busy_cnt != 0) $display("FAIL zero_busy got %0d busy cycles want 0", busy_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [15:0] exp_w [8] = '{16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006, 16'h1007, 16'h1000, 16'h1001};
    clear_mon();
    bus.out_ready = 1'b1; bus.start_addr = 3'd2; bus.count = 4'd12; bus.start = 1'b1;
    tick();
    bus.start_addr = 3'd5; bus.count = 4'd3;
    repeat (4) tick();
    bus.start = 1'b0;
    wait_done(60, ok);
    repeat (5) tick();
    total_cnt++; if (ok !== 1'b1 || out_q.size() != 8)
      $display("FAIL b2b_total got ok=%b words=%0d want 1,8", ok, out_q.size()); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++; if (out_q[i] !== exp_w[i]) $display("FAIL b2b_word%0d got %h want %h", i, out_q[i], exp_w[i]); else pass_cnt++;
    end
    total_cnt++; if (done_cnt != 1) $display("FAIL b2b_done_pulses got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    clear_mon();
    bus.out_ready = 1'b1; bus.start_addr = 3'd0; bus.count = 4'd6; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_q.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    total_cnt++; if (ok !== 1'b1 || out_q.size() != 2)
      $display("FAIL midrst_two_words got ok=%b words=%0d want 1,2", ok, out_q.size()); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if ({bus.busy, bus.done, bus.rf_enable_read, bus.out_valid} !== 4'b0000)
      $display("FAIL midrst_flags got %b want 0000", {bus.busy, bus.done, bus.rf_enable_read, bus.out_valid}); else pass_cnt++;
    total_cnt++; if (bus.rf_addr !== 3'd0 || bus.out_data !== 16'h0000)
      $display("FAIL midrst_bus got addr=%0d data=%h want 0,0000", bus.rf_addr, bus.out_data); else pass_cnt++;
    repeat (2) tick();
    reset = 1'b0;
    clear_mon();
    repeat (12) tick();
    total_cnt++; if (out_q.size() != 0 || busy_cnt != 0)
      $display("FAIL midrst_stale got words=%0d busy=%0d want 0,0", out_q.size(), busy_cnt); else pass_cnt++;
    total_cnt++; if (done_cnt != 0) $display("FAIL midrst_done got %0d want 0", done_cnt); else pass_cnt++;
  endtask

  initial begin
    bus.start = 1'b0; bus.start_addr = 3'd0; bus.count = 4'd0; bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_count_zero();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
